// File: rtl/alu_mdu.sv
// EX-stage ALU with signed-overflow detection, plus an iterative shift-add
// multiplier / restoring divider that writes HI/LO after WIDTH cycles.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_SLT  = 5'd5;
  localparam logic [4:0] OP_SLTU = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_NOR  = 5'd8;
  localparam logic [4:0] OP_LUI  = 5'd9;
  localparam logic [4:0] OP_SRL  = 5'd10;
  localparam logic [4:0] OP_SRA  = 5'd11;
  localparam logic [4:0] OP_XOR  = 5'd12;
  localparam logic [4:0] OP_MFHI = 5'd13;
  localparam logic [4:0] OP_MFLO = 5'd14;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] work_hi_reg, work_lo_reg;
  logic [WIDTH-1:0] operand_reg, dividend_reg;
  logic [SHW-1:0]   count_reg;
  logic             md_div_reg, neg_q_reg, neg_r_reg, div_zero_reg;

  // ---------------------------------------------------------------------
  // Barrel shifter: one right shifter; SLL reuses it on bit-reversed B.
  // ---------------------------------------------------------------------
  logic [SHW-1:0]           sh;
  logic                     shift_left, shift_fill;
  logic [WIDTH-1:0]         b_rev, shr_in, shr_out, shl_out;
  logic [SHW:0][WIDTH-1:0]  shr_stage;

  assign sh         = A[SHW-1:0];
  assign shift_left = (ALUOp == OP_SLL);
  assign shift_fill = (ALUOp == OP_SRA) & B[MSB];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign b_rev[gi]   = B[WIDTH-1-gi];
      assign shl_out[gi] = shr_out[WIDTH-1-gi];
    end
  endgenerate

  assign shr_in       = shift_left ? b_rev : B;
  assign shr_stage[0] = shr_in;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_shr
      assign shr_stage[gi+1] = sh[gi]
        ? {{(2**gi){shift_fill}}, shr_stage[gi][WIDTH-1:2**gi]}
        : shr_stage[gi];
    end
  endgenerate

  assign shr_out = shr_stage[SHW];

  // ---------------------------------------------------------------------
  // Combinational result path
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sum, diff;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    C        = A;
    Overflow = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        C        = sum;
        Overflow = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB: begin
        C        = diff;
        Overflow = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_AND:  C = A & B;
      OP_OR:   C = A | B;
      OP_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  C = shl_out;
      OP_NOR:  C = ~(A | B);
      OP_LUI:  C = B << (WIDTH / 2);
      OP_SRL:  C = shr_out;
      OP_SRA:  C = shr_out;
      OP_XOR:  C = A ^ B;
      OP_MFHI: C = hi_reg;
      OP_MFLO: C = lo_reg;
      default: C = A;
    endcase
  end

  assign Zero = (C == '0);

  // ---------------------------------------------------------------------
  // Multiply/divide datapath. Both run on operand magnitudes; signs are
  // re-applied when HI/LO are written.
  // ---------------------------------------------------------------------
  logic             start_ok, op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_ok  = start && (ALUOp[4:2] == 3'b100);
  assign op_signed = ~ALUOp[0];
  assign a_mag     = (op_signed && A[MSB]) ? -A : A;
  assign b_mag     = (op_signed && B[MSB]) ? -B : B;

  logic [WIDTH:0]   mul_sum, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign mul_sum   = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : '0);
  assign div_trial = {work_hi_reg, work_lo_reg[MSB]} - {1'b0, operand_reg};
  // Partial remainder stays below the divisor, so the trial MSB is a clean sign.
  assign div_ok    = ~div_trial[WIDTH];

  assign step_hi = md_div_reg
    ? (div_ok ? div_trial[WIDTH-1:0] : {work_hi_reg[WIDTH-2:0], work_lo_reg[MSB]})
    : mul_sum[WIDTH:1];
  assign step_lo = md_div_reg
    ? {work_lo_reg[WIDTH-2:0], div_ok}
    : {mul_sum[0], work_lo_reg[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   hi_final, lo_final;

  assign prod_raw = {step_hi, step_lo};
  assign prod_fix = neg_q_reg ? -prod_raw : prod_raw;

  always_comb begin
    hi_final = prod_fix[2*WIDTH-1:WIDTH];
    lo_final = prod_fix[WIDTH-1:0];
    if (md_div_reg) begin
      if (div_zero_reg) begin
        hi_final = dividend_reg;
        lo_final = '1;
      end else begin
        hi_final = neg_r_reg ? -step_hi : step_hi;
        lo_final = neg_q_reg ? -step_lo : step_lo;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (count_reg == LAST_ITER) state_next = DONE;
      DONE:    state_next = start_ok ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg       <= '0;
      lo_reg       <= '0;
      work_hi_reg  <= '0;
      work_lo_reg  <= '0;
      operand_reg  <= '0;
      dividend_reg <= '0;
      count_reg    <= '0;
      md_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (state_reg != RUN && start_ok) begin
      work_hi_reg  <= '0;
      work_lo_reg  <= a_mag;
      operand_reg  <= b_mag;
      dividend_reg <= A;
      count_reg    <= '0;
      md_div_reg   <= ALUOp[1];
      neg_q_reg    <= op_signed & (A[MSB] ^ B[MSB]);
      neg_r_reg    <= op_signed & A[MSB];
      div_zero_reg <= (B == '0);
    end else if (state_reg == RUN) begin
      work_hi_reg <= step_hi;
      work_lo_reg <= step_lo;
      count_reg   <= count_reg + 1'b1;
      if (count_reg == LAST_ITER) begin
        hi_reg <= hi_final;
        lo_reg <= lo_final;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed and randomized ALU/MDU steps, checked against an
// arithmetic reference model; a second 16-bit instance covers width scaling.
module tb_alu_mdu;

  logic        clk, rst;
  logic [31:0] A, B, C, hi, lo;
  logic [4:0]  ALUOp;
  logic        start, Zero, Overflow, busy, done;

  logic [15:0] A16, B16, C16, hi16, lo16;
  logic [4:0]  ALUOp16;
  logic        start16, Zero16, Overflow16, busy16, done16;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUOp(ALUOp), .start(start),
    .C(C), .Zero(Zero), .Overflow(Overflow), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(A16), .B(B16), .ALUOp(ALUOp16), .start(start16),
    .C(C16), .Zero(Zero16), .Overflow(Overflow16), .busy(busy16), .done(done16),
    .hi(hi16), .lo(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU straight from the operation table, using wide arithmetic.
  function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output logic [31:0] c, output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint lim_hi = (longint'(1) <<< 31) - 1;
    longint lim_lo = -(longint'(1) <<< 31);
    longint s;
    int sh = int'(a[4:0]);
    c = a;
    ovf = 1'b0;
    case (op)
      5'd1:  begin s = sa + sb; c = s[31:0]; ovf = (s > lim_hi) || (s < lim_lo); end
      5'd2:  begin s = sa - sb; c = s[31:0]; ovf = (s > lim_hi) || (s < lim_lo); end
      5'd3:  c = a & b;
      5'd4:  c = a | b;
      5'd5:  c = (sa < sb) ? 32'd1 : 32'd0;
      5'd6:  c = (a < b) ? 32'd1 : 32'd0;
      5'd7:  c = b << sh;
      5'd8:  c = ~(a | b);
      5'd9:  c = b << 16;
      5'd10: c = b >> sh;
      5'd11: c = $signed(b) >>> sh;
      5'd12: c = a ^ b;
      5'd13: c = h;
      5'd14: c = l;
      default: c = a;
    endcase
  endfunction

  // Reference multiply/divide for the 32-bit instance.
  function automatic void mdu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q, r;
    logic [63:0] p;
    case (op)
      5'd16: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      5'd17: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
      5'd18: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = '0; l = 32'h8000_0000; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Launch one MDU op from the current cycle and follow it to its DONE cycle.
  task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int inject);
    logic busy_ok = 1'b1;
    logic hold_ok = 1'b1;
    A = a; B = b; ALUOp = op; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      if (i == 5) begin
        ALUOp = 5'd13;
        #1;
        check({tag, "_mfhi_during_run"}, C, exp_hi);
        ALUOp = op;
      end
      if (i == inject) begin
        A = $urandom; B = $urandom; ALUOp = 5'd19; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_busy_window"}, busy_ok, 1'b1);
    check({tag, "_hilo_hold"}, hold_ok, 1'b1);
    check({tag, "_done_busy"}, {done, busy}, 2'b10);
    check({tag, "_hilo"}, {hi, lo}, {eh, el});
    ALUOp = 5'd14;
    #1;
    check({tag, "_mflo"}, C, el);
    exp_hi = eh;
    exp_lo = el;
    $display("md %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi, lo);
  endtask

  task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eh, input logic [15:0] el);
    logic busy_ok = 1'b1;
    A16 = a; B16 = b; ALUOp16 = op; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (busy16 !== 1'b1 || done16 !== 1'b0) busy_ok = 1'b0;
      tick();
    end
    check({tag, "_busy_window16"}, busy_ok, 1'b1);
    check({tag, "_done16"}, {done16, busy16}, 2'b10);
    check({tag, "_hilo16"}, {hi16, lo16}, {eh, el});
    $display("md16 %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, a, b, hi16, lo16);
  endtask

  task automatic alu_dir(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ec, input logic ez, input logic eo);
    tick();
    ALUOp = op; A = a; B = b;
    #1;
    check({tag, "_C"}, C, ec);
    check({tag, "_Zero"}, Zero, ez);
    check({tag, "_Ovf"}, Overflow, eo);
    $display("alu %s op=%0d a=%h b=%h -> C=%h Z=%b V=%b", tag, op, a, b, C, Zero, Overflow);
  endtask

  initial begin
    logic [31:0] rh, rl, rc, ra, rb;
    logic        rv, flag;
    logic [4:0]  rop;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; ALUOp = '0;
    start16 = 1'b0; A16 = '0; B16 = '0; ALUOp16 = '0;
    repeat (2) tick();
    check("reset_state", {busy, done, hi, lo}, '0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {busy, done}, 2'b00);

    // Directed ALU cases
    alu_dir("add_ovf",  5'd1,  32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0, 1'b0 | 1'b1);
    alu_dir("sub_zero", 5'd2,  32'd5,         32'd5,          32'd0,         1'b1, 1'b0);
    alu_dir("sra",      5'd11, 32'd4,         32'h8000_0000,  32'hF800_0000, 1'b0, 1'b0);
    alu_dir("slt",      5'd5,  32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1'b0);
    alu_dir("sltu",     5'd6,  32'hFFFF_FFFF, 32'd1,          32'd0,         1'b1, 1'b0);
    alu_dir("sub_ovf",  5'd2,  32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1);

    // Start with a non-MDU op must not launch anything
    tick();
    ALUOp = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) flag = 1'b1;
      tick();
    end
    check("start_add_no_busy", flag, 1'b0);

    // Directed MDU cases; consecutive calls start in the DONE cycle
    run_md("mult_neg3x5",  5'd16, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_md("divu_100_7",   5'd19, 32'd100,       32'd7,         32'd2,         32'd14,        0);
    run_md("div_m7_2",     5'd18, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    tick();
    run_md("div_min_m1",   5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 0);
    run_md("divu_9_0",     5'd19, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, 0);
    mdu_ref(5'd17, 32'h1234_5678, 32'h9ABC_DEF0, rh, rl);
    run_md("start_in_run", 5'd17, 32'h1234_5678, 32'h9ABC_DEF0, rh, rl, 8);
    tick();
    check("done_one_cycle", {done, busy}, 2'b00);

    // Randomized MDU ops
    for (int n = 0; n < 10; n++) begin
      rop = 5'd16 + 5'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 1) rb = 32'd0;
      if (n % 4 == 2) rb = 32'($urandom_range(1, 20));
      mdu_ref(rop, ra, rb, rh, rl);
      run_md("rand_md", rop, ra, rb, rh, rl, 0);
      if (n % 3 == 0) tick();
    end

    // Randomized ALU ops (MFHI/MFLO see the last MDU result)
    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom;
      if (n % 5 == 0) rb = ra;
      alu_ref(rop, ra, rb, exp_hi, exp_lo, rc, rv);
      alu_dir("rand_alu", rop, ra, rb, rc, (rc == 32'd0), rv);
    end

    // 16-bit instance
    tick();
    run16("multu16_ffff", 5'd17, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    for (int n = 0; n < 4; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (n == 3) b16 = 16'd0;
      if (n % 2 == 0) begin
        p16 = {16'd0, a16} * {16'd0, b16};
        run16("rand_multu16", 5'd17, a16, b16, p16[31:16], p16[15:0]);
      end else if (b16 == 16'd0) begin
        run16("rand_divu16", 5'd19, a16, b16, a16, 16'hFFFF);
      end else begin
        run16("rand_divu16", 5'd19, a16, b16, a16 % b16, a16 / b16);
      end
    end
    tick();
    ALUOp16 = 5'd9; B16 = 16'h00AB; A16 = 16'h1234;
    #1;
    check("lui16", C16, 16'hAB00);
    $display("alu16 lui b=%h -> C=%h", B16, C16);

    // Reset in the middle of an operation aborts it
    tick();
    A = 32'd1234; B = 32'd77; ALUOp = 5'd17; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("busy_before_abort", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {busy, done, hi, lo}, '0);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) flag = 1'b1;
      tick();
    end
    check("no_done_after_abort", flag, 1'b0);
    $display("abort hi=%h lo=%h", hi, lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
